plic_claim_master: RTL and testbench
====================================

Name: plic_claim_master

Overview:
- Wishbone initiator that services the PLIC's single-context external IRQ in hardware: claims, dispatches, then completes.
- On external_irq it reads the PLIC claim/complete register and hands the claimed source ID to a local consumer (DMA sequencer, accelerator, or CPU shim) over a valid/ready handshake.
- After the consumer signals done, it writes the same ID back to the claim/complete register.
- Sits between the PLIC's Wishbone slave port (or the bus arbiter) and the consumer.

Parameters:
- CLAIM_ADDR, 24'h200004, byte address of the context-0 claim/complete register.
- ACK_TIMEOUT, 16, cycles to wait for wb_ack_i before aborting a transfer (≥2).
- HOLDOFF, 2, idle cycles after completion or a zero claim before external_irq_i is sampled again.
- CNT_W, 16, width of the saturating claim counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- en_i  in  1  enable; sampled only in IDLE
- external_irq_i  in  1  PLIC irq output
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  24  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  ack; may be combinational, i.e. asserted in the same cycle as stb
- irq_valid_o  out  1  claimed ID available
- irq_id_o  out  SOURCE_ID_WIDTH  claimed source ID
- irq_ready_i  in  1  consumer accepts the ID
- done_i  in  1  single-cycle pulse: servicing finished
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  single-cycle pulse on bus timeout
- claim_cnt_o  out  CNT_W  count of nonzero claims, saturating

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge) drives every output to 0, FSM to IDLE, all counters to 0.
- Reset mid-transfer drops cyc/stb on the next edge. No complete is issued; the PLIC is reset on the same line.
- All bus outputs are registered. wb_sel_o is 4'hF whenever stb is high. wb_adr_o is CLAIM_ADDR during both transfers.
- IDLE: when en_i & external_irq_i are high at edge N, cyc/stb/we=0 are asserted from cycle N+1; go to CLAIM_RD.
- CLAIM_RD: hold cyc/stb until wb_ack_i is sampled high.
  - On ack, capture wb_dat_i[SOURCE_ID_WIDTH-1:0] and deassert cyc/stb on that edge.
  - ID==0 (spurious) → HOLDOFF, no dispatch, counter unchanged.
  - ID≠0 → DISPATCH, claim_cnt_o +1 (saturating at all-ones).
- DISPATCH: irq_valid_o=1 with irq_id_o stable until irq_ready_i is sampled high; then valid drops and the FSM goes to SERVICE.
  - With combinational ack, valid rises 2 cycles after the irq sample.
- SERVICE: wait for done_i. done_i outside SERVICE is ignored.
  - done_i arriving in the same cycle as the ready handshake is ignored; the consumer must pulse done_i later.
- COMPLETE_WR: cyc/stb/we=1, wb_dat_o = zero-extended ID, held until ack; then → HOLDOFF.
  - irq_id_o keeps the last ID until the next claim.
- HOLDOFF: count HOLDOFF cycles with the bus idle, then → IDLE. This covers the PLIC's registered irq update.
- Timeout: in CLAIM_RD or COMPLETE_WR, a counter starts at 0 on entry and increments each cycle without ack.
  - When it reaches ACK_TIMEOUT-1 with no ack: drop cyc/stb, pulse err_o for 1 cycle, → HOLDOFF.
  - A claim that timed out is never dispatched or completed.
  - An ack arriving in the same cycle as the limit wins: no error.
- en_i low does not abort a claim in progress.
- busy_o = (state != IDLE).
- Bus handshake rule: stb never rises in the same cycle that ack is consumed. There is at least one idle cycle between the claim read and the complete write.

Decomposition:
- plic_pkg gains:
  - the claim-master state enum typedef (IDLE, CLAIM_RD, DISPATCH, SERVICE, COMPLETE_WR, HOLDOFF);
  - CLAIM_OFFSET = 24'h200004;
  - a reuse of the existing SOURCE_ID_WIDTH.
- Natural sub-module: wb_single_master, owning cyc/stb/we/adr/dat/sel registers, the ack wait and the timeout counter.
  - Requests a single read or write and returns done/rdata/timeout.
  - The top keeps the FSM, handshake and counters.

Test Plan:
- Responder with combinational ack returns 5; irq high at cycle 0 → stb read at cycle 1, irq_valid_o=1 with irq_id_o=5 at cycle 2; ready at 3; done at 6 → write of data 5 to 24'h200004 with sel 4'hF; claim_cnt_o=1.
- Responder returns 0 → no irq_valid_o, no write transfer, claim_cnt_o stays 0, idle after HOLDOFF.
- Responder never acks the read, ACK_TIMEOUT=16 → cyc drops after 16 stb cycles, one-cycle err_o, no dispatch.
- irq_ready_i held low for 10 cycles → irq_valid_o and irq_id_o stay stable and no bus activity occurs; completes normally after ready.
- wb_rst_i asserted during SERVICE with ID 7 → all outputs 0 next cycle, no complete written, with irq still high a new claim starts after release.
- Responder ack delayed 3 cycles on both transfers → cyc/stb held exactly until ack, correct data on both, no err_o.

Source files
------------

// File: rtl/plic_claim_master_pkg.sv
// Shared types and constants for the PLIC claim/complete bus master.
package plic_claim_master_pkg;

  localparam int SOURCE_ID_WIDTH = 10;
  localparam int WB_ADR_W = 24;
  localparam int WB_DAT_W = 32;
  localparam logic [WB_ADR_W-1:0] CLAIM_OFFSET = 24'h200004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAIM_RD,
    ST_DISPATCH,
    ST_SERVICE,
    ST_COMPLETE_WR,
    ST_HOLDOFF
  } claimState_e;

  // The complete write carries the claimed ID zero-extended to the bus width.
  function automatic logic [WB_DAT_W-1:0] idToWord(input logic [SOURCE_ID_WIDTH-1:0] id);
    return {{(WB_DAT_W-SOURCE_ID_WIDTH){1'b0}}, id};
  endfunction

endpackage

// File: rtl/plic_claim_master_if.sv
// Wishbone single-master bus bundle between the claim master and the PLIC slave port.
interface plic_claim_master_if;
  import plic_claim_master_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] datW;
  logic [3:0]          sel;
  logic [WB_DAT_W-1:0] datR;
  logic                ack;

  modport master (output cyc, stb, we, adr, datW, sel, input datR, ack);
  modport slave  (input cyc, stb, we, adr, datW, sel, output datR, ack);

endinterface

// File: rtl/plic_claim_master_wb.sv
// Registered single-transfer Wishbone initiator with an ack timeout.
module wb_single_master
  import plic_claim_master_pkg::*;
#(
  parameter logic [WB_ADR_W-1:0] ADDR        = CLAIM_OFFSET,
  parameter int                  ACK_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic                done_o,
  output logic                timeout_o,
  output logic [WB_DAT_W-1:0] rdata_o,
  plic_claim_master_if.master wb
);

  localparam int TO_W = $clog2(ACK_TIMEOUT);

  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic                ackSeen;
  logic                limitHit;

  // An ack on the limit cycle takes priority over the timeout.
  assign ackSeen  = cyc_q & wb.ack;
  assign limitHit = cyc_q & ~wb.ack & (toCnt_q == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    toCnt_d = toCnt_q;
    if (ackSeen || limitHit) begin
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      adr_d   = '0;
      dat_d   = '0;
      sel_d   = 4'h0;
      toCnt_d = '0;
    end else if (req_i && !cyc_q) begin
      cyc_d   = 1'b1;
      we_d    = we_i;
      adr_d   = ADDR;
      dat_d   = we_i ? wdata_i : '0;
      sel_d   = 4'hF;
      toCnt_d = '0;
    end else if (cyc_q) begin
      toCnt_d = toCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= 4'h0;
      toCnt_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      toCnt_q <= toCnt_d;
    end
  end

  assign wb.cyc    = cyc_q;
  assign wb.stb    = cyc_q;
  assign wb.we     = we_q;
  assign wb.adr    = adr_q;
  assign wb.datW   = dat_q;
  assign wb.sel    = sel_q;
  assign done_o    = ackSeen;
  assign timeout_o = limitHit;
  assign rdata_o   = wb.datR;

endmodule

// File: rtl/plic_claim_master.sv
// Claims the PLIC external IRQ over Wishbone, hands the ID to a consumer, then completes it.
module plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter logic [WB_ADR_W-1:0] CLAIM_ADDR  = CLAIM_OFFSET,
  parameter int                  ACK_TIMEOUT = 16,
  parameter int                  HOLDOFF     = 2,
  parameter int                  CNT_W       = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       en_i,
  input  logic                       external_irq_i,
  plic_claim_master_if.master        wb,
  output logic                       irq_valid_o,
  output logic [SOURCE_ID_WIDTH-1:0] irq_id_o,
  input  logic                       irq_ready_i,
  input  logic                       done_i,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           claim_cnt_o
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  claimState_e                state_q, state_d;
  logic [SOURCE_ID_WIDTH-1:0] id_q, id_d;
  logic [CNT_W-1:0]           claimCnt_q, claimCnt_d;
  logic [HOLD_W-1:0]          holdCnt_q, holdCnt_d;
  logic                       err_q, err_d;
  logic                       busReq;
  logic                       busWe;
  logic                       busDone;
  logic                       busTimeout;
  logic [WB_DAT_W-1:0]        busRdata;
  logic                       unusedRdataHi;

  assign unusedRdataHi = ^busRdata[WB_DAT_W-1:SOURCE_ID_WIDTH];

  wb_single_master #(
    .ADDR        (CLAIM_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_bus (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_i     (busReq),
    .we_i      (busWe),
    .wdata_i   (idToWord(id_q)),
    .done_o    (busDone),
    .timeout_o (busTimeout),
    .rdata_o   (busRdata),
    .wb        (wb)
  );

  // Bus requests are issued on the sampling edge so cyc/stb rise the following cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    claimCnt_d = claimCnt_q;
    holdCnt_d  = '0;
    err_d      = 1'b0;
    busReq     = 1'b0;
    busWe      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i && external_irq_i) begin
          busReq  = 1'b1;
          state_d = ST_CLAIM_RD;
        end
      end
      ST_CLAIM_RD: begin
        if (busDone) begin
          if (busRdata[SOURCE_ID_WIDTH-1:0] == '0) begin
            state_d = ST_HOLDOFF;
          end else begin
            id_d    = busRdata[SOURCE_ID_WIDTH-1:0];
            state_d = ST_DISPATCH;
            if (claimCnt_q != '1) claimCnt_d = claimCnt_q + 1'b1;
          end
        end else if (busTimeout) begin
          err_d   = 1'b1;
          state_d = ST_HOLDOFF;
        end
      end
      ST_DISPATCH: begin
        if (irq_ready_i) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (done_i) begin
          busReq  = 1'b1;
          busWe   = 1'b1;
          state_d = ST_COMPLETE_WR;
        end
      end
      ST_COMPLETE_WR: begin
        if (busDone) begin
          state_d = ST_HOLDOFF;
        end else if (busTimeout) begin
          err_d   = 1'b1;
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (holdCnt_q == HOLD_W'(HOLDOFF - 1)) state_d = ST_IDLE;
        else holdCnt_d = holdCnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      claimCnt_q <= '0;
      holdCnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      claimCnt_q <= claimCnt_d;
      holdCnt_q  <= holdCnt_d;
      err_q      <= err_d;
    end
  end

  assign irq_valid_o = (state_q == ST_DISPATCH);
  assign irq_id_o    = id_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;
  assign claim_cnt_o = claimCnt_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed bench for plic_claim_master: per-cycle vector table plus multi-cycle corner sequences.
module tb_plic_claim_master;
  import plic_claim_master_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [23:0] CA = 24'h200004;
  localparam logic [23:0] A0 = 24'h0;
  localparam logic [31:0] D0 = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic en, irq, rdy, dn;
  logic valid, busy, err;
  logic [SOURCE_ID_WIDTH-1:0] id;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  plic_claim_master_if wbIf();

  plic_claim_master #(
    .CLAIM_ADDR  (24'h200004),
    .ACK_TIMEOUT (16),
    .HOLDOFF     (2),
    .CNT_W       (16)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .en_i           (en),
    .external_irq_i (irq),
    .wb             (wbIf),
    .irq_valid_o    (valid),
    .irq_id_o       (id),
    .irq_ready_i    (rdy),
    .done_i         (dn),
    .busy_o         (busy),
    .err_o          (err),
    .claim_cnt_o    (cnt)
  );

  // Slave responder: acks after ackDelay wait cycles, zero delay means a combinational ack.
  logic        respEnable;
  int          ackDelay;
  logic [31:0] respData;
  int          waitCnt = 0;

  assign wbIf.ack  = respEnable && wbIf.stb && (waitCnt >= ackDelay);
  assign wbIf.datR = respData;

  always @(posedge clk) begin
    if (!wbIf.stb || wbIf.ack) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  // Bus and handshake activity monitor, sampled on the edge that consumes it.
  int          reads = 0, writes = 0, stbCycles = 0, validCycles = 0, errCycles = 0;
  logic [31:0] lastWrDat = '0;
  logic [23:0] lastWrAdr = '0;
  logic [3:0]  lastWrSel = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (wbIf.stb) stbCycles <= stbCycles + 1;
      if (valid) validCycles <= validCycles + 1;
      if (err) errCycles <= errCycles + 1;
      if (wbIf.cyc && wbIf.stb && wbIf.ack) begin
        if (wbIf.we) begin
          writes    <= writes + 1;
          lastWrDat <= wbIf.datW;
          lastWrAdr <= wbIf.adr;
          lastWrSel <= wbIf.sel;
        end else begin
          reads <= reads + 1;
        end
      end
    end
  end

  typedef struct {
    logic                       en, irq, rdy, dn;
    logic                       cyc, stb, we;
    logic [23:0]                adr;
    logic [31:0]                dat;
    logic [3:0]                 sel;
    logic                       valid;
    logic [SOURCE_ID_WIDTH-1:0] id;
    logic                       busy, err;
    logic [15:0]                cnt;
  } vec_t;

  vec_t vecs[13];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic i, input logic r, input logic d);
    en  = e;
    irq = i;
    rdy = r;
    dn  = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int i);
    checkOutput($sformatf("v%0d cyc", i), 32'(wbIf.cyc), 32'(vecs[i].cyc));
    checkOutput($sformatf("v%0d stb", i), 32'(wbIf.stb), 32'(vecs[i].stb));
    checkOutput($sformatf("v%0d we", i), 32'(wbIf.we), 32'(vecs[i].we));
    checkOutput($sformatf("v%0d adr", i), 32'(wbIf.adr), 32'(vecs[i].adr));
    checkOutput($sformatf("v%0d dat", i), wbIf.datW, vecs[i].dat);
    checkOutput($sformatf("v%0d sel", i), 32'(wbIf.sel), 32'(vecs[i].sel));
    checkOutput($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
    checkOutput($sformatf("v%0d id", i), 32'(id), 32'(vecs[i].id));
    checkOutput($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    checkOutput($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
    checkOutput($sformatf("v%0d cnt", i), 32'(cnt), 32'(vecs[i].cnt));
  endtask

  initial begin
    int r0, w0, s0, v0, e0;
    logic stable;

    //                en irq rdy dn   cyc stb we adr dat    sel    valid id      busy err cnt
    vecs[0]  = '{L, H, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd0,  L, L, 16'd0};
    vecs[1]  = '{H, H, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd0,  L, L, 16'd0};
    vecs[2]  = '{H, H, L, L,  H, H, L, CA, D0,    4'hF,  L, 10'd0,  H, L, 16'd0};
    vecs[3]  = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  H, 10'd5,  H, L, 16'd1};
    vecs[4]  = '{H, L, H, H,  L, L, L, A0, D0,    4'h0,  H, 10'd5,  H, L, 16'd1};
    vecs[5]  = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  H, L, 16'd1};
    vecs[6]  = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  H, L, 16'd1};
    vecs[7]  = '{H, L, L, H,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  H, L, 16'd1};
    vecs[8]  = '{H, L, L, L,  H, H, H, CA, 32'd5, 4'hF,  L, 10'd5,  H, L, 16'd1};
    vecs[9]  = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  H, L, 16'd1};
    vecs[10] = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  H, L, 16'd1};
    vecs[11] = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  L, L, 16'd1};
    vecs[12] = '{H, L, L, L,  L, L, L, A0, D0,    4'h0,  L, 10'd5,  L, L, 16'd1};

    rst = 1'b1;
    applyStimulus(L, L, L, L);
    respEnable = 1'b1;
    ackDelay   = 0;
    respData   = 32'd5;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] basic claim/dispatch/complete with combinational ack");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].en, vecs[i].irq, vecs[i].rdy, vecs[i].dn);
      checkVec(i);
      tick();
    end
    checkOutput("basic reads", 32'(reads), 32'd1);
    checkOutput("basic writes", 32'(writes), 32'd1);
    checkOutput("basic wr adr", 32'(lastWrAdr), 32'h200004);
    checkOutput("basic wr dat", lastWrDat, 32'd5);
    checkOutput("basic wr sel", 32'(lastWrSel), 32'hF);

    $display("[TB] spurious zero claim");
    respData = 32'd0;
    r0 = reads; w0 = writes; v0 = validCycles;
    applyStimulus(H, H, L, L);
    tick();
    applyStimulus(H, L, L, L);
    tick();
    checkOutput("zero holdoff busy", 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput("zero idle busy", 32'(busy), 32'd0);
    checkOutput("zero read done", 32'(reads - r0), 32'd1);
    checkOutput("zero no write", 32'(writes - w0), 32'd0);
    checkOutput("zero no valid", 32'(validCycles - v0), 32'd0);
    checkOutput("zero cnt", 32'(cnt), 32'd1);

    $display("[TB] read ack timeout");
    respEnable = 1'b0;
    respData   = 32'd5;
    s0 = stbCycles; e0 = errCycles; v0 = validCycles; r0 = reads;
    applyStimulus(H, H, L, L);
    tick();
    applyStimulus(H, L, L, L);
    for (int k = 0; k < 40 && !err; k++) tick();
    checkOutput("timeout err", 32'(err), 32'd1);
    checkOutput("timeout cyc dropped", 32'(wbIf.cyc), 32'd0);
    checkOutput("timeout stb cycles", 32'(stbCycles - s0), 32'd16);
    tick();
    checkOutput("timeout err single", 32'(err), 32'd0);
    for (int k = 0; k < 10 && busy; k++) tick();
    checkOutput("timeout idle", 32'(busy), 32'd0);
    checkOutput("timeout err count", 32'(errCycles - e0), 32'd1);
    checkOutput("timeout no valid", 32'(validCycles - v0), 32'd0);
    checkOutput("timeout no read", 32'(reads - r0), 32'd0);
    checkOutput("timeout cnt", 32'(cnt), 32'd1);
    respEnable = 1'b1;

    $display("[TB] consumer stalls ready, en dropped mid-claim");
    respData = 32'd9;
    applyStimulus(H, H, L, L);
    tick();
    applyStimulus(L, L, L, L);
    for (int k = 0; k < 10 && !valid; k++) tick();
    checkOutput("stall valid", 32'(valid), 32'd1);
    checkOutput("stall id", 32'(id), 32'd9);
    s0 = stbCycles;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!valid || id !== 10'd9 || wbIf.cyc) stable = 1'b0;
      tick();
    end
    checkOutput("stall stable", 32'(stable), 32'd1);
    checkOutput("stall bus idle", 32'(stbCycles - s0), 32'd0);
    applyStimulus(L, L, H, L);
    tick();
    applyStimulus(L, L, L, L);
    tick();
    checkOutput("stall service valid", 32'(valid), 32'd0);
    checkOutput("stall service busy", 32'(busy), 32'd1);
    w0 = writes;
    applyStimulus(L, L, L, H);
    tick();
    applyStimulus(L, L, L, L);
    for (int k = 0; k < 10 && busy; k++) tick();
    checkOutput("stall idle", 32'(busy), 32'd0);
    checkOutput("stall write", 32'(writes - w0), 32'd1);
    checkOutput("stall wr dat", lastWrDat, 32'd9);
    checkOutput("stall cnt", 32'(cnt), 32'd2);

    $display("[TB] reset during service");
    respData = 32'd7;
    applyStimulus(H, H, L, L);
    tick();
    for (int k = 0; k < 10 && !valid; k++) tick();
    checkOutput("rst claim id", 32'(id), 32'd7);
    applyStimulus(H, H, H, L);
    tick();
    applyStimulus(H, H, L, L);
    checkOutput("rst in service", 32'(busy && !valid), 32'd1);
    w0 = writes;
    rst = 1'b1;
    tick();
    checkOutput("rst cyc", 32'(wbIf.cyc), 32'd0);
    checkOutput("rst stb", 32'(wbIf.stb), 32'd0);
    checkOutput("rst we", 32'(wbIf.we), 32'd0);
    checkOutput("rst adr", 32'(wbIf.adr), 32'd0);
    checkOutput("rst dat", wbIf.datW, 32'd0);
    checkOutput("rst sel", 32'(wbIf.sel), 32'd0);
    checkOutput("rst valid", 32'(valid), 32'd0);
    checkOutput("rst id", 32'(id), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5 && !wbIf.stb; k++) tick();
    checkOutput("rst reclaim stb", 32'(wbIf.stb), 32'd1);
    checkOutput("rst reclaim read", 32'(wbIf.we), 32'd0);
    tick();
    applyStimulus(H, L, L, L);
    checkOutput("rst reclaim valid", 32'(valid), 32'd1);
    checkOutput("rst reclaim cnt", 32'(cnt), 32'd1);
    checkOutput("rst no complete", 32'(writes - w0), 32'd0);
    applyStimulus(H, L, H, L);
    tick();
    applyStimulus(H, L, L, H);
    tick();
    applyStimulus(H, L, L, L);
    for (int k = 0; k < 10 && busy; k++) tick();
    checkOutput("rst reclaim done", 32'(busy), 32'd0);
    checkOutput("rst reclaim wr dat", lastWrDat, 32'd7);

    $display("[TB] ack delayed three cycles on both transfers");
    ackDelay = 3;
    respData = 32'd12;
    s0 = stbCycles; e0 = errCycles;
    applyStimulus(H, H, L, L);
    tick();
    applyStimulus(H, L, L, L);
    for (int k = 0; k < 20 && !valid; k++) tick();
    checkOutput("slow valid", 32'(valid), 32'd1);
    checkOutput("slow id", 32'(id), 32'd12);
    checkOutput("slow rd stb cycles", 32'(stbCycles - s0), 32'd4);
    applyStimulus(H, L, H, L);
    tick();
    applyStimulus(H, L, L, H);
    tick();
    applyStimulus(H, L, L, L);
    s0 = stbCycles; w0 = writes;
    for (int k = 0; k < 20 && busy; k++) tick();
    checkOutput("slow idle", 32'(busy), 32'd0);
    checkOutput("slow wr stb cycles", 32'(stbCycles - s0), 32'd4);
    checkOutput("slow write", 32'(writes - w0), 32'd1);
    checkOutput("slow wr dat", lastWrDat, 32'd12);
    checkOutput("slow wr adr", 32'(lastWrAdr), 32'h200004);
    checkOutput("slow no err", 32'(errCycles - e0), 32'd0);
    checkOutput("slow cnt", 32'(cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
